branch_resolve_queue: RTL and testbench
=======================================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
- REQ-001: Parameter DEPTH, default 4, number of in-flight predicted branches held; power of two, 2..16.
- REQ-002: Parameter ADDR_W, default 32, PC/target width.
- REQ-003: Parameter GHR_BITS, default 8, width of GHR snapshot and predictor index.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst  input  1  asynchronous, active-high reset.
- REQ-006: pred_valid  input  1  fetch presents a predicted branch.
- REQ-007: pred_pc  input  ADDR_W  branch PC.
- REQ-008: pred_taken  input  1  predictor's direction.
- REQ-009: pred_target  input  ADDR_W  predicted target; ignored when pred_taken=0.
- REQ-010: pred_ghr  input  GHR_BITS  GHR value used for the prediction.
- REQ-011: pred_ready  output  1  queue accepts an entry this cycle.
- REQ-012: res_valid  input  1  execute resolves the oldest branch.
- REQ-013: res_taken  input  1  actual direction.
- REQ-014: res_target  input  ADDR_W  actual target.
- REQ-015: flush  output  1  one-cycle mispredict pulse.
- REQ-016: redirect_pc  output  ADDR_W  correct fetch PC, valid while flush=1.
- REQ-017: upd_valid  output  1  one-cycle predictor-update pulse.
- REQ-018: upd_index  output  GHR_BITS  predictor table index.
- REQ-019: upd_taken  output  1  outcome for counter and GHR update.
- REQ-020: occupancy  output  $clog2(DEPTH)+1  valid entries.
- REQ-021: res_err  output  1  sticky; res_valid seen while queue empty.

Function
- REQ-022: Enqueue on pred_valid&&pred_ready; entry {pc, taken, target, ghr} written at tail, tail increments modulo DEPTH.
- REQ-023: pred_ready = !full && state==RUN; combinational from registered state only.
- REQ-024: res_valid with queue non-empty dequeues head in the same edge; resolution strictly in program order.
- REQ-025: Mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target).
- REQ-026: Every dequeue produces upd_valid=1 on the next cycle, upd_index = head.pc[GHR_BITS-1:0] ^ head.ghr, upd_taken = res_taken.
- REQ-027: On mispredict: next cycle flush=1, redirect_pc = res_taken ? res_target : head.pc+4 (wrap modulo 2^ADDR_W); all entries discarded, occupancy=0.
- REQ-028: States RUN, FLUSH; RUN->FLUSH on mispredict; FLUSH->RUN unconditionally after one cycle; pred_ready=0 and res_valid ignored in FLUSH.
- REQ-029: Enqueue in same cycle as mispredicting dequeue is dropped.
- REQ-030: Simultaneous correct dequeue and enqueue: occupancy unchanged; allowed when full only if dequeue, since pred_ready reflects pre-edge full.
- REQ-031: res_valid with empty queue: no dequeue, no upd_valid, res_err set until reset.
- REQ-032: Pointers wrap modulo DEPTH; full/empty distinguished by occupancy, not pointer equality.

Reset
- REQ-033: rst asserted: state=RUN, pointers=0, occupancy=0, flush=0, upd_valid=0, redirect_pc=0, upd_index=0, upd_taken=0, res_err=0; entry storage need not reset.
- REQ-034: rst mid-operation discards all entries; no flush or upd_valid pulse emitted for them.

Configuration
- REQ-035: Macro BRQ_STATS_EN defined: outputs stat_resolved[15:0], stat_mispred[15:0] count dequeues and mispredicts, saturate at 16'hFFFF, reset to 0.
- REQ-036: BRQ_STATS_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
- REQ-037: Shared package bp_pkg holds ADDR_W, GHR_BITS defaults, the queue entry struct, and state enum {RUN, FLUSH}.
- REQ-038: Storage and pointers in sub-module brq_fifo; compare, FSM, update outputs in top.

Verification
- REQ-039: Enqueue 4 entries, DEPTH=4 -> pred_ready=0, occupancy=4; 5th pred_valid not accepted.
- REQ-040: Head {pc=0x100, taken=1, target=0x200, ghr=0x0F}, res taken to 0x200 -> no flush; upd_valid=1, upd_index=0x0F, upd_taken=1 next cycle.
- REQ-041: Head {pc=0x1FC, taken=1}, res_taken=0 -> flush=1, redirect_pc=0x200, occupancy=0, pred_ready=0 one cycle.
- REQ-042: Head taken to 0x300, res taken to 0x304 -> flush=1, redirect_pc=0x304.
- REQ-043: res_valid with empty queue -> res_err=1, upd_valid=0; rst clears res_err.
- REQ-044: Full queue, correct res plus pred_valid same cycle -> dequeue only; next cycle pred_ready=1, occupancy=3.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue: default widths, queue entry layout, FSM states.
// Entries are laid out at the package widths; the queue's ADDR_W/GHR_BITS default to these.
package bp_pkg;

    localparam int BP_ADDR_W   = 32;
    localparam int BP_GHR_BITS = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } brq_state_e;

    typedef struct packed {
        logic [BP_ADDR_W-1:0]   pc;
        logic                   taken;
        logic [BP_ADDR_W-1:0]   target;
        logic [BP_GHR_BITS-1:0] ghr;
    } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor-facing signals of the branch resolve queue.
// Optional BRQ_STATS_EN adds the resolved/mispredict statistics counters.
interface branch_resolve_queue_if #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int GHR_BITS = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic                pred_valid;
    logic [ADDR_W-1:0]   pred_pc;
    logic                pred_taken;
    logic [ADDR_W-1:0]   pred_target;
    logic [GHR_BITS-1:0] pred_ghr;
    logic                pred_ready;
    logic                res_valid;
    logic                res_taken;
    logic [ADDR_W-1:0]   res_target;
    logic                flush;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                upd_valid;
    logic [GHR_BITS-1:0] upd_index;
    logic                upd_taken;
    logic [OCC_W-1:0]    occupancy;
    logic                res_err;
`ifdef BRQ_STATS_EN
    logic [15:0]         stat_resolved;
    logic [15:0]         stat_mispred;
`endif

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target, pred_ghr,
        output res_valid, res_taken, res_target,
        input  pred_ready, flush, redirect_pc, upd_valid, upd_index, upd_taken,
        input  occupancy, res_err
`ifdef BRQ_STATS_EN
        , input stat_resolved, stat_mispred
    );
`else
    );
`endif

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target, pred_ghr,
        input  res_valid, res_taken, res_target,
        output pred_ready, flush, redirect_pc, upd_valid, upd_index, upd_taken,
        output occupancy, res_err
`ifdef BRQ_STATS_EN
        , output stat_resolved, stat_mispred
    );
`else
    );
`endif

endinterface

// File: rtl/branch_resolve_queue_fifo.sv
// brq_fifo: circular storage of in-flight predicted branches with head/tail pointers.
// Fullness comes from the occupancy count so wrapped pointers never look ambiguous.
module brq_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  brq_entry_t                 wr_entry,
    output brq_entry_t                 head_entry,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    brq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[tail_q] <= wr_entry;
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;
    assign full       = (count_q == OCC_W'(DEPTH));
    assign empty      = (count_q == '0);

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: checks in-order branch resolutions against stored predictions,
// emits predictor updates and mispredict flush/redirect. `define BRQ_STATS_EN adds counters.
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = BP_ADDR_W,
    parameter int GHR_BITS = BP_GHR_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_resolve_queue_if.slave  bus
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    brq_state_e          state_q, state_d;
    brq_entry_t          wr_entry, head_entry;
    logic [OCC_W-1:0]    count;
    logic                full, empty;
    logic                in_run, enq, res_act, deq, mispred;
    logic                flush_q, flush_d;
    logic [ADDR_W-1:0]   redirect_q, redirect_d;
    logic                upd_valid_q, upd_valid_d;
    logic [GHR_BITS-1:0] upd_index_q, upd_index_d;
    logic                upd_taken_q, upd_taken_d;
    logic                res_err_q, res_err_d;

    assign in_run         = (state_q == RUN);
    assign bus.pred_ready = !full && in_run;
    assign enq            = bus.pred_valid && bus.pred_ready;
    assign res_act        = bus.res_valid && in_run;
    assign deq            = res_act && !empty;
    assign mispred        = deq && ((bus.res_taken != head_entry.taken) ||
                            (bus.res_taken && (BP_ADDR_W'(bus.res_target) != head_entry.target)));

    always_comb begin
        wr_entry.pc     = BP_ADDR_W'(bus.pred_pc);
        wr_entry.taken  = bus.pred_taken;
        wr_entry.target = BP_ADDR_W'(bus.pred_target);
        wr_entry.ghr    = BP_GHR_BITS'(bus.pred_ghr);
    end

    // A mispredict wipes the queue, including any entry offered on the same edge.
    brq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (enq && !mispred),
        .pop        (deq),
        .clear      (mispred),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        state_d     = mispred ? FLUSH : RUN;
        flush_d     = mispred;
        redirect_d  = redirect_q;
        if (mispred)
            redirect_d = bus.res_taken ? bus.res_target : ADDR_W'(head_entry.pc) + ADDR_W'(3'd4);
        upd_valid_d = deq;
        upd_index_d = upd_index_q;
        upd_taken_d = upd_taken_q;
        if (deq) begin
            upd_index_d = GHR_BITS'(head_entry.pc[BP_GHR_BITS-1:0] ^ head_entry.ghr);
            upd_taken_d = bus.res_taken;
        end
        res_err_d   = res_err_q | (res_act && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            upd_valid_q <= 1'b0;
            upd_index_q <= '0;
            upd_taken_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            upd_valid_q <= upd_valid_d;
            upd_index_q <= upd_index_d;
            upd_taken_q <= upd_taken_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_index   = upd_index_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.occupancy   = count;
    assign bus.res_err     = res_err_q;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_resolved_q, stat_resolved_d;
    logic [15:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mispred_d  = stat_mispred_q;
        if (deq && (stat_resolved_q != 16'hFFFF))    stat_resolved_d = stat_resolved_q + 16'd1;
        if (mispred && (stat_mispred_q != 16'hFFFF)) stat_mispred_d  = stat_mispred_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign bus.stat_resolved = stat_resolved_q;
    assign bus.stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: queue-based reference model, directed corner
// cases followed by randomized prediction/resolution traffic with occasional resets.
module tb_branch_resolve_queue;
    import bp_pkg::*;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 32;
    localparam int GHR_BITS = 8;

    typedef struct {
        logic [ADDR_W-1:0]   pc;
        logic                taken;
        logic [ADDR_W-1:0]   target;
        logic [GHR_BITS-1:0] ghr;
    } br_t;

    typedef struct {
        int                  due;
        logic                fl;
        logic [ADDR_W-1:0]   redirect;
        logic [GHR_BITS-1:0] idx;
        logic                taken;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GHR_BITS(GHR_BITS)) bus ();

    branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GHR_BITS(GHR_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    br_t  m_q[$];
    exp_t sb[$];
    logic m_flush = 1'b0;
    logic m_err   = 1'b0;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, got, want, edge_cnt);
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs and advances the model past the next rising edge.
    task automatic applyStimulus(input logic pv, input logic [ADDR_W-1:0] pc, input logic tk,
                                 input logic [ADDR_W-1:0] tg, input logic [GHR_BITS-1:0] ghr,
                                 input logic rv, input logic rtk, input logic [ADDR_W-1:0] rtg);
        br_t  h;
        exp_t e;
        logic ready, act, mis;
        bus.pred_valid  = pv;
        bus.pred_pc     = pc;
        bus.pred_taken  = tk;
        bus.pred_target = tg;
        bus.pred_ghr    = ghr;
        bus.res_valid   = rv;
        bus.res_taken   = rtk;
        bus.res_target  = rtg;
        ready = (m_q.size() < DEPTH) && !m_flush;
        act   = rv && !m_flush;
        mis   = 1'b0;
        if (act && m_q.size() == 0) begin
            m_err = 1'b1;
        end else if (act) begin
            h = m_q.pop_front();
            if (rtk != h.taken)                mis = 1'b1;
            else if (rtk && (rtg != h.target)) mis = 1'b1;
            e.due      = edge_cnt + 1;
            e.fl       = mis;
            e.redirect = rtk ? rtg : h.pc + ADDR_W'(4);
            e.idx      = h.pc[GHR_BITS-1:0] ^ h.ghr;
            e.taken    = rtk;
            sb.push_back(e);
            if (mis) m_q.delete();
        end
        if (pv && ready && !mis) begin
            h.pc = pc; h.taken = tk; h.target = tg; h.ghr = ghr;
            m_q.push_back(h);
        end
        m_flush = mis;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.pred_valid = 1'b0;
        bus.res_valid  = 1'b0;
        m_q.delete();
        m_flush = 1'b0;
        m_err   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares status every cycle and pops the scoreboard whenever an update/flush appears.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            checkOutput("occupancy", 64'(bus.occupancy), 64'(m_q.size()));
            checkOutput("pred_ready", 64'(bus.pred_ready), 64'((m_q.size() < DEPTH) && !m_flush));
            checkOutput("res_err", 64'(bus.res_err), 64'(m_err));
            if (bus.upd_valid || bus.flush) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: upd_valid=%0b flush=%0b, expected no output at edge %0d",
                             bus.upd_valid, bus.flush, edge_cnt);
                end else begin
                    e = sb.pop_front();
                    checkOutput("output_timing", 64'(edge_cnt), 64'(e.due));
                    checkOutput("upd_valid", 64'(bus.upd_valid), 64'd1);
                    checkOutput("flush", 64'(bus.flush), 64'(e.fl));
                    checkOutput("upd_index", 64'(bus.upd_index), 64'(e.idx));
                    checkOutput("upd_taken", 64'(bus.upd_taken), 64'(e.taken));
                    if (e.fl) checkOutput("redirect_pc", 64'(bus.redirect_pc), 64'(e.redirect));
                end
            end else if (sb.size() != 0 && sb[0].due <= edge_cnt) begin
                e = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("[TB] FAIL missing_output: upd_valid=0 flush=0, expected update due at edge %0d", e.due);
            end
        end
    end

    initial begin
        logic                pv, tk, rv, rtk;
        logic [ADDR_W-1:0]   pc, tg, rtg;
        logic [GHR_BITS-1:0] ghr;

        bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.pred_taken = 1'b0;
        bus.pred_target = '0;  bus.pred_ghr = '0;
        bus.res_valid = 1'b0;  bus.res_taken = 1'b0; bus.res_target = '0;
        doReset();
        checkOutput("reset_flush", 64'(bus.flush), 64'd0);
        checkOutput("reset_redirect", 64'(bus.redirect_pc), 64'd0);
        checkOutput("reset_upd_index", 64'(bus.upd_index), 64'd0);

        $display("[TB] directed: fill, full-queue resolve+enqueue, mispredicts, empty resolve");
        applyStimulus(1, 32'h100, 1, 32'h200, 8'h0F, 0, 0, '0);
        applyStimulus(1, 32'h120, 0, 32'h0,   8'h11, 0, 0, '0);
        applyStimulus(1, 32'h140, 1, 32'h180, 8'h22, 0, 0, '0);
        applyStimulus(1, 32'h160, 0, 32'h0,   8'h44, 0, 0, '0);
        applyStimulus(1, 32'h999, 1, 32'h123, 8'h55, 0, 0, '0);
        applyStimulus(1, 32'h1FC, 1, 32'h280, 8'h05, 1, 1, 32'h200);
        applyStimulus(1, 32'h1FC, 1, 32'h280, 8'h05, 0, 0, '0);
        applyStimulus(0, '0, 0, '0, '0, 1, 0, '0);
        applyStimulus(0, '0, 0, '0, '0, 1, 1, 32'h180);
        applyStimulus(0, '0, 0, '0, '0, 1, 0, '0);
        applyStimulus(0, '0, 0, '0, '0, 1, 0, '0);
        applyStimulus(1, 32'h777, 1, 32'h888, 8'h01, 1, 1, '0);
        applyStimulus(1, 32'h400, 1, 32'h300, 8'hA5, 0, 0, '0);
        applyStimulus(1, 32'h404, 0, 32'h0,   8'h5A, 1, 1, 32'h304);
        idle();
        applyStimulus(0, '0, 0, '0, '0, 1, 1, 32'h10);
        idle();
        doReset();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                doReset();
            end else begin
                pv  = ($urandom_range(0, 9) < 6);
                pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
                tk  = 1'($urandom_range(0, 1));
                tg  = $urandom() & 32'hFFFF_FFFC;
                ghr = GHR_BITS'($urandom());
                rv  = ($urandom_range(0, 9) < 4);
                if (m_q.size() > 0) begin
                    rtk = ($urandom_range(0, 9) < 8) ? m_q[0].taken : ~m_q[0].taken;
                    rtg = ($urandom_range(0, 9) < 8) ? m_q[0].target : ($urandom() & 32'hFFFF_FFFC);
                end else begin
                    rtk = 1'($urandom_range(0, 1));
                    rtg = $urandom();
                end
                applyStimulus(pv, pc, tk, tg, ghr, rv, rtk, rtg);
            end
        end
        idle();
        idle();
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
